// File: rtl/alu.sv
// Registered integer ALU for the execute stage: one-cycle latency, new op every cycle.
// Optional shift codes (SLL/SRL/SRA) are built only when ALU_SHIFT_EN is defined.
module alu #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CTRL_W-1:0]       ALU_Control,
    input  logic [WIDTH-1:0]        operand_A,
    input  logic [WIDTH-1:0]        operand_B,
    output logic signed [WIDTH-1:0] ALU_result
);

    localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(6'b000000);
    localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(6'b001000);
    localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(6'b000010);
    localparam logic [CTRL_W-1:0] OP_SLTU = CTRL_W'(6'b000011);
    localparam logic [CTRL_W-1:0] OP_XOR  = CTRL_W'(6'b000100);
    localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(6'b000110);
    localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(6'b000111);
    localparam logic [CTRL_W-1:0] OP_NOR  = CTRL_W'(6'b000101);
`ifdef ALU_SHIFT_EN
    localparam logic [CTRL_W-1:0] OP_SLL  = CTRL_W'(6'b000001);
    localparam logic [CTRL_W-1:0] OP_SRL  = CTRL_W'(6'b001001);
    localparam logic [CTRL_W-1:0] OP_SRA  = CTRL_W'(6'b001101);
    localparam int                SHW     = $clog2(WIDTH);

    logic [SHW-1:0] shamt;
    assign shamt = operand_B[SHW-1:0];
`endif

    logic [WIDTH-1:0] result_d;
    logic             lt_s;
    logic             lt_u;

    // Direct signed compare stays correct where the sign of A-B would overflow.
    assign lt_s = $signed(operand_A) < $signed(operand_B);
    assign lt_u = operand_A < operand_B;

    always_comb begin
        result_d = '0;
        case (ALU_Control)
            OP_ADD:  result_d = operand_A + operand_B;
            OP_SUB:  result_d = operand_A - operand_B;
            OP_SLT:  result_d = WIDTH'(lt_s);
            OP_SLTU: result_d = WIDTH'(lt_u);
            OP_XOR:  result_d = operand_A ^ operand_B;
            OP_OR:   result_d = operand_A | operand_B;
            OP_AND:  result_d = operand_A & operand_B;
            OP_NOR:  result_d = ~(operand_A | operand_B);
`ifdef ALU_SHIFT_EN
            OP_SLL:  result_d = operand_A << shamt;
            OP_SRL:  result_d = operand_A >> shamt;
            OP_SRA:  result_d = WIDTH'($signed(operand_A) >>> shamt);
`endif
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ALU_result <= '0;
        else        ALU_result <= $signed(result_d);
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; define ALU_SHIFT_EN here and in the RTL build
// together to exercise the shift codes.
module tb_alu;

    localparam logic [5:0] ADD  = 6'b000000;
    localparam logic [5:0] SUB  = 6'b001000;
    localparam logic [5:0] SLT  = 6'b000010;
    localparam logic [5:0] SLTU = 6'b000011;
    localparam logic [5:0] XOR_ = 6'b000100;
    localparam logic [5:0] OR_  = 6'b000110;
    localparam logic [5:0] AND_ = 6'b000111;
    localparam logic [5:0] NOR_ = 6'b000101;
    localparam logic [5:0] SLL  = 6'b000001;
    localparam logic [5:0] SRL  = 6'b001001;
    localparam logic [5:0] SRA  = 6'b001101;

    logic               clk;
    logic               rst_n;
    logic [5:0]         ALU_Control;
    logic [31:0]        operand_A;
    logic [31:0]        operand_B;
    logic signed [31:0] ALU_result;

    int checks = 0;
    int errors = 0;

    alu #(.WIDTH(32), .CTRL_W(6)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ALU_Control(ALU_Control),
        .operand_A(operand_A),
        .operand_B(operand_B),
        .ALU_result(ALU_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply at negedge, let one rising edge register it, sample 1 time unit later.
    task automatic run_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALU_Control = c;
        operand_A   = a;
        operand_B   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        ALU_Control = ADD; operand_A = 32'd4; operand_B = 32'd5;
        rst_n = 1'b0;
        #1;
        got = ALU_result;
        checks++;
        if (got !== 32'h0) begin
            errors++; $display("FAIL reset_initial got %h exp %h", got, 32'h0);
        end
        @(negedge clk); rst_n = 1'b1;
        run_op(ADD, 32'h1234, 32'h1);
        got = ALU_result;
        checks++;
        if (got !== 32'h1235) begin
            errors++; $display("FAIL reset_pre got %h exp %h", got, 32'h1235);
        end
        // Assert reset away from any edge: output must clear without a clock.
        #2 rst_n = 1'b0;
        #1;
        got = ALU_result;
        checks++;
        if (got !== 32'h0) begin
            errors++; $display("FAIL reset_async got %h exp %h", got, 32'h0);
        end
        @(posedge clk); #1;
        got = ALU_result;
        checks++;
        if (got !== 32'h0) begin
            errors++; $display("FAIL reset_hold got %h exp %h", got, 32'h0);
        end
        @(negedge clk); rst_n = 1'b1;
        run_op(ADD, 32'd4, 32'd5);
        got = ALU_result;
        checks++;
        if (got !== 32'd9) begin
            errors++; $display("FAIL reset_release got %h exp %h", got, 32'd9);
        end
    endtask

    task automatic test_arith();
        logic [5:0]  c [4] = '{ADD, SUB, SUB, ADD};
        logic [31:0] a [4] = '{32'd4, 32'd4, 32'd4, 32'h7FFFFFFF};
        logic [31:0] b [4] = '{32'd5, 32'd5, 32'hFFFFFFFF, 32'd1};
        logic [31:0] e [4] = '{32'd9, 32'hFFFFFFFF, 32'd5, 32'h80000000};
        logic [31:0] got;
        for (int i = 0; i < 4; i++) begin
            run_op(c[i], a[i], b[i]);
            got = ALU_result;
            checks++;
            if (got !== e[i]) begin
                errors++; $display("FAIL arith[%0d] got %h exp %h", i, got, e[i]);
            end
        end
    endtask

    task automatic test_compare();
        logic [5:0]  c [7] = '{SLT, SLT, SLT, SLT, SLTU, SLT, SLTU};
        logic [31:0] a [7] = '{32'd4, 32'hFFFFFFF0, 32'hFFFFFFFE, 32'd7, 32'd4,
                               32'h80000000, 32'd7};
        logic [31:0] b [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7,
                               32'hFFFFFFFF, 32'd1, 32'd7};
        logic [31:0] e [7] = '{32'd0, 32'd1, 32'd1, 32'd0, 32'd1, 32'd1, 32'd0};
        logic [31:0] got;
        for (int i = 0; i < 7; i++) begin
            run_op(c[i], a[i], b[i]);
            got = ALU_result;
            checks++;
            if (got !== e[i]) begin
                errors++; $display("FAIL compare[%0d] got %h exp %h", i, got, e[i]);
            end
        end
    endtask

    task automatic test_logic();
        logic [5:0]  c [6] = '{XOR_, AND_, OR_, NOR_, XOR_, AND_};
        logic [31:0] a [6] = '{32'h26, 32'h26, 32'h26, 32'h26, 32'd4, 32'd4};
        logic [31:0] b [6] = '{32'h35, 32'h35, 32'h35, 32'h35, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] e [6] = '{32'h13, 32'h24, 32'h37, 32'hFFFFFFC8, 32'hFFFFFFFB, 32'd4};
        logic [31:0] got;
        for (int i = 0; i < 6; i++) begin
            run_op(c[i], a[i], b[i]);
            got = ALU_result;
            checks++;
            if (got !== e[i]) begin
                errors++; $display("FAIL logic[%0d] got %h exp %h", i, got, e[i]);
            end
        end
    endtask

    task automatic test_codes();
        logic [31:0] got;
        run_op(6'b111111, 32'h1234_5678, 32'h0F0F_0F0F);
        got = ALU_result;
        checks++;
        if (got !== 32'h0) begin
            errors++; $display("FAIL code_111111 got %h exp %h", got, 32'h0);
        end
        run_op(6'b100000, 32'd4, 32'd5);
        got = ALU_result;
        checks++;
        if (got !== 32'h0) begin
            errors++; $display("FAIL code_100000 got %h exp %h", got, 32'h0);
        end
`ifdef ALU_SHIFT_EN
        run_op(SRA, 32'h80000000, 32'h24);
        got = ALU_result;
        checks++;
        if (got !== 32'hF8000000) begin
            errors++; $display("FAIL sra got %h exp %h", got, 32'hF8000000);
        end
        run_op(SLL, 32'd1, 32'd31);
        got = ALU_result;
        checks++;
        if (got !== 32'h80000000) begin
            errors++; $display("FAIL sll got %h exp %h", got, 32'h80000000);
        end
        run_op(SRL, 32'h80000000, 32'hFFFFFFE4);
        got = ALU_result;
        checks++;
        if (got !== 32'h08000000) begin
            errors++; $display("FAIL srl got %h exp %h", got, 32'h08000000);
        end
`else
        run_op(SLL, 32'd1, 32'd31);
        got = ALU_result;
        checks++;
        if (got !== 32'h0) begin
            errors++; $display("FAIL noshift_sll got %h exp %h", got, 32'h0);
        end
        run_op(SRL, 32'h80000000, 32'd4);
        got = ALU_result;
        checks++;
        if (got !== 32'h0) begin
            errors++; $display("FAIL noshift_srl got %h exp %h", got, 32'h0);
        end
        run_op(SRA, 32'h80000000, 32'd4);
        got = ALU_result;
        checks++;
        if (got !== 32'h0) begin
            errors++; $display("FAIL noshift_sra got %h exp %h", got, 32'h0);
        end
`endif
    endtask

    // New op every cycle; each result must line up with the op issued one edge earlier.
    task automatic test_back_to_back();
        logic [5:0]  c [6] = '{ADD, SUB, XOR_, SLTU, NOR_, AND_};
        logic [31:0] a [6] = '{32'd10, 32'd3, 32'hAAAA5555, 32'd1, 32'h0, 32'hF0F0F0F0};
        logic [31:0] b [6] = '{32'd20, 32'd10, 32'hFFFF0000, 32'd2, 32'h0, 32'h0FF00FF0};
        logic [31:0] e [6] = '{32'd30, 32'hFFFFFFF9, 32'h5555555, 32'd1, 32'hFFFFFFFF,
                               32'h00F000F0};
        logic [31:0] got;
        e[2] = 32'h5555_5555;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                got = ALU_result;
                checks++;
                if (got !== e[i-1]) begin
                    errors++; $display("FAIL b2b[%0d] got %h exp %h", i-1, got, e[i-1]);
                end
            end
            if (i < 6) begin
                ALU_Control = c[i];
                operand_A   = a[i];
                operand_B   = b[i];
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ALU_Control = '0;
        operand_A = '0;
        operand_B = '0;
        test_reset();
        test_arith();
        test_compare();
        test_logic();
        test_codes();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
